// File: rtl/icache_line_fetch_if.sv
// ----------------------------------------------------------------------------
// icache_line_fetch_if
// Bundles the CPU fetch handshake and the line-RAM bus of icache_line_fetch.
//
// Signals:
//   req_valid/req_ready/req_addr[13:0] : CPU fetch request handshake
//   resp_valid/resp_data[31:0]         : one-cycle response pulse, no backpressure
//   flush                              : single-cycle invalidate-all pulse
//   mem_cs/mem_we/mem_addr_valid       : RAM control (mem_we is always 0)
//   mem_addr[13:0]                     : RAM line address {tag, index, 6'b0}
//   mem_data_ready/mem_data_i[511:0]   : RAM line return
//
// Modports:
//   slave  : the cache side (drives responses and the RAM request)
//   master : the environment side (CPU plus RAM)
// ----------------------------------------------------------------------------
interface icache_line_fetch_if;
    logic         req_valid;
    logic         req_ready;
    logic [13:0]  req_addr;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         flush;
    logic         mem_cs;
    logic         mem_we;
    logic         mem_addr_valid;
    logic [13:0]  mem_addr;
    logic         mem_data_ready;
    logic [511:0] mem_data_i;

    modport slave (
        input  req_valid, req_addr, flush, mem_data_ready, mem_data_i,
        output req_ready, resp_valid, resp_data, mem_cs, mem_we,
               mem_addr_valid, mem_addr
    );

    modport master (
        output req_valid, req_addr, flush, mem_data_ready, mem_data_i,
        input  req_ready, resp_valid, resp_data, mem_cs, mem_we,
               mem_addr_valid, mem_addr
    );
endinterface

// File: rtl/icache_line_fetch.sv
// ----------------------------------------------------------------------------
// icache_line_fetch
// Direct-mapped, read-only instruction cache sitting between the CPU fetch
// stage and a 512-bit line RAM. Hits answer one cycle after acceptance; a miss
// fetches the whole 64-byte line, installs it, and then answers.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   bus        : icache_line_fetch_if.slave (CPU handshake + RAM bus)
//   hit_count  : (ICACHE_STATS_EN only) saturating count of accepted hits
//   miss_count : (ICACHE_STATS_EN only) saturating count of accepted misses
//
// Parameters:
//   LINES_LOG2 : log2 of the number of lines (1..7)
//
// Optional feature macro: ICACHE_STATS_EN (adds hit/miss counters).
// ----------------------------------------------------------------------------
module icache_line_fetch #(
    parameter int LINES_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    icache_line_fetch_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int LINES = 1 << LINES_LOG2;
    localparam int TAG_W = 8 - LINES_LOG2;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t                  state;
    state_t                  state_next;

    logic [511:0]            data_array [LINES];
    logic [TAG_W-1:0]        tag_array  [LINES];
    logic [LINES-1:0]        valid_bits;

    logic [13:0]             lat_addr;
    logic                    fill_flushed;
    logic                    resp_valid_q;
    logic [31:0]             resp_data_q;

    logic                    req_ready_c;
    logic                    accept;
    logic                    lookup_hit;
    logic                    mem_cs_c;
    logic                    mem_addr_valid_c;
    logic [13:0]             mem_addr_c;
    logic                    fill_done;

    logic [LINES_LOG2-1:0]   req_index;
    logic [TAG_W-1:0]        req_tag;
    logic [3:0]              req_word;
    logic [LINES_LOG2-1:0]   lat_index;
    logic [TAG_W-1:0]        lat_tag;
    logic [3:0]              lat_word;

    assign req_index = bus.req_addr[5+LINES_LOG2:6];
    assign req_tag   = bus.req_addr[13:6+LINES_LOG2];
    assign req_word  = bus.req_addr[5:2];
    assign lat_index = lat_addr[5+LINES_LOG2:6];
    assign lat_tag   = lat_addr[13:6+LINES_LOG2];
    assign lat_word  = lat_addr[5:2];

    assign lookup_hit = valid_bits[req_index] && (tag_array[req_index] == req_tag);
    assign fill_done  = (state == FILL) && bus.mem_data_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus outputs. req_ready is also held low while reset is
    // asserted so the CPU never sees the cache as ready during reset; a flush
    // in the same cycle takes priority over a request.
    always_comb begin
        state_next       = state;
        req_ready_c      = 1'b0;
        accept           = 1'b0;
        mem_cs_c         = 1'b0;
        mem_addr_valid_c = 1'b0;
        mem_addr_c       = '0;
        case (state)
            IDLE: begin
                req_ready_c = rst_n && !bus.flush;
                accept      = bus.req_valid && req_ready_c;
                if (accept && !lookup_hit) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mem_cs_c         = 1'b1;
                mem_addr_valid_c = 1'b1;
                mem_addr_c       = {lat_addr[13:6], 6'b0};
                if (bus.mem_data_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line storage has no reset; the valid bits alone decide what is usable.
    always_ff @(posedge clk) begin
        if (rst_n && fill_done) begin
            data_array[lat_index] <= bus.mem_data_i;
            tag_array[lat_index]  <= lat_tag;
        end
    end

    // Request latch, response register and valid bits. A flush seen at any
    // point of a fill is remembered in fill_flushed so the line that finally
    // arrives is returned but not marked valid. Flush is applied last so it
    // overrides a same-edge valid-bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_bits   <= '0;
            lat_addr     <= '0;
            fill_flushed <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (accept) begin
                lat_addr     <= bus.req_addr;
                fill_flushed <= 1'b0;
                if (lookup_hit) begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= data_array[req_index][{req_word, 5'b0} +: 32];
                end
            end
            if (fill_done) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= bus.mem_data_i[{lat_word, 5'b0} +: 32];
                if (!fill_flushed) begin
                    valid_bits[lat_index] <= 1'b1;
                end
            end
            if (bus.flush) begin
                valid_bits <= '0;
                if (state == FILL) begin
                    fill_flushed <= 1'b1;
                end
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss counters; untouched by flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (lookup_hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else begin
                if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
`endif

    assign bus.req_ready      = req_ready_c;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.mem_cs         = mem_cs_c;
    assign bus.mem_we         = 1'b0;
    assign bus.mem_addr_valid = mem_addr_valid_c;
    assign bus.mem_addr       = mem_addr_c;

endmodule
